// File: rtl/glitch_mon_ctrl.sv
// glitch_mon_ctrl
// Arms a bank of NCH glitch detectors and collects their sticky error flags.
// The controller holds the detectors disabled while they settle, enables the
// selected channels, then captures per-channel errors, the first failing
// channel and a saturating event count.
//
// Ports:
//   clk          sole clock
//   rst          asynchronous, active-low reset
//   start        pulse: arm using ch_en_mask (only accepted in IDLE)
//   stop         pulse: return to IDLE from any state
//   clr          pulse: clear captured status (HALT also re-enters SETTLE)
//   ch_en_mask   channel enables, latched when start is accepted
//   err_in       detector error flags, asynchronous to clk, sticky-high
//   det_dis      per-channel detector disable, 1 = disabled
//   state        0 IDLE, 1 SETTLE, 2 ARMED, 3 HALT
//   err_sticky   per-channel captured error
//   first_valid  first_ch holds a captured channel
//   first_ch     lowest-index channel of the first error cycle
//   err_cnt      saturating count of captured channel errors
//   irq          registered OR of err_sticky
module glitch_mon_ctrl #(
    parameter int NCH         = 8,
    parameter int SETTLE_CYC  = 16,
    parameter int CNT_W       = 8,
    parameter int HALT_ON_ERR = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 stop,
    input  logic                                 clr,
    input  logic [NCH-1:0]                       ch_en_mask,
    input  logic [NCH-1:0]                       err_in,
    output logic [NCH-1:0]                       det_dis,
    output logic [1:0]                           state,
    output logic [NCH-1:0]                       err_sticky,
    output logic                                 first_valid,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] first_ch,
    output logic [CNT_W-1:0]                     err_cnt,
    output logic                                 irq
);

    localparam int FW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ARMED  = 2'd2,
        HALT   = 2'd3
    } state_t;

    state_t          st;
    logic [NCH-1:0]  sync_p0;     // first synchronizer flop
    logic [NCH-1:0]  sync_p1;     // synchronized flags (s)
    logic [NCH-1:0]  prev_p1;     // previous synchronized flags (e)
    logic [NCH-1:0]  mask_q;
    logic [SW-1:0]   settle_cnt;
    logic [NCH-1:0]  new_err;

    // Popcount of a channel vector; NCH <= 32 fits in 6 bits.
    function automatic logic [5:0] popcount(input logic [NCH-1:0] v);
        logic [5:0] p;
        p = '0;
        for (int i = 0; i < NCH; i++) begin
            p = p + {5'd0, v[i]};
        end
        return p;
    endfunction

    // Lowest set index; scanning downward leaves the lowest one last.
    function automatic logic [FW-1:0] lowest_idx(input logic [NCH-1:0] v);
        logic [FW-1:0] idx;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = FW'(i);
            end
        end
        return idx;
    endfunction

    // Add with saturation at the all-ones counter value.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [5:0]       b);
        logic [CNT_W+6:0] sum;
        sum = {7'd0, a} + {{(CNT_W + 1){1'b0}}, b};
        if (sum > {7'd0, {CNT_W{1'b1}}}) begin
            return {CNT_W{1'b1}};
        end
        return sum[CNT_W-1:0];
    endfunction

    // Only rising edges of enabled channels count, and only while ARMED.
    assign new_err = (st == ARMED) ? (sync_p1 & ~prev_p1 & mask_q) : '0;
    assign state   = st;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st          <= IDLE;
            sync_p0     <= '0;
            sync_p1     <= '0;
            prev_p1     <= '0;
            mask_q      <= '0;
            settle_cnt  <= '0;
            det_dis     <= '1;
            err_sticky  <= '0;
            first_valid <= 1'b0;
            first_ch    <= '0;
            err_cnt     <= '0;
            irq         <= 1'b0;
        end else begin
            // stage p0 -> p1: two-flop synchronizer
            sync_p0 <= err_in;
            sync_p1 <= sync_p0;

            // Status clear; a same-cycle new error below overrides it.
            if (clr) begin
                err_sticky  <= '0;
                first_valid <= 1'b0;
                first_ch    <= '0;
                err_cnt     <= '0;
                irq         <= 1'b0;
            end else begin
                irq <= |err_sticky;
            end

            case (st)
                IDLE: begin
                    if (start && !stop) begin
                        mask_q     <= ch_en_mask;
                        settle_cnt <= SETTLE_LOAD;
                        st         <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        // Flags already high at arming are treated as old news.
                        prev_p1 <= sync_p1;
                        det_dis <= ~mask_q;
                        st      <= ARMED;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ARMED: begin
                    prev_p1 <= sync_p1;
                    if (new_err != '0) begin
                        err_sticky <= (clr ? '0 : err_sticky) | new_err;
                        err_cnt    <= sat_add(clr ? '0 : err_cnt, popcount(new_err));
                        if (clr || !first_valid) begin
                            first_valid <= 1'b1;
                            first_ch    <= lowest_idx(new_err);
                        end
                        if (HALT_ON_ERR != 0) begin
                            det_dis <= '1;
                            st      <= HALT;
                        end
                    end
                end
                HALT: begin
                    if (clr) begin
                        settle_cnt <= SETTLE_LOAD;
                        st         <= SETTLE;
                    end
                end
                default: st <= IDLE;
            endcase

            // stop overrides any state transition taken above.
            if (stop) begin
                det_dis <= '1;
                st      <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_glitch_mon_ctrl.sv
// Bench for glitch_mon_ctrl: two instances share one stimulus stream.
// Instance A uses the defaults (halt on error, 8-bit count); instance B keeps
// monitoring and has a 2-bit counter. A cycle-level model of each instance
// is checked on every falling edge, plus hand-computed literal checks.
module tb_glitch_mon_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, clr = 1'b0;
    logic [7:0] mask = 8'h00;
    logic [7:0] err_in = 8'h00;

    logic [7:0] dis_a, stk_a, dis_b, stk_b;
    logic [1:0] state_a, state_b;
    logic       fv_a, fv_b, irq_a, irq_b;
    logic [2:0] fch_a, fch_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    glitch_mon_ctrl #(.NCH(8), .SETTLE_CYC(16), .CNT_W(8), .HALT_ON_ERR(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr),
        .ch_en_mask(mask), .err_in(err_in), .det_dis(dis_a), .state(state_a),
        .err_sticky(stk_a), .first_valid(fv_a), .first_ch(fch_a),
        .err_cnt(cnt_a), .irq(irq_a));

    glitch_mon_ctrl #(.NCH(8), .SETTLE_CYC(16), .CNT_W(2), .HALT_ON_ERR(0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr),
        .ch_en_mask(mask), .err_in(err_in), .det_dis(dis_b), .state(state_b),
        .err_sticky(stk_b), .first_valid(fv_b), .first_ch(fch_b),
        .err_cnt(cnt_b), .irq(irq_b));

    // ---------------- behavioural model ----------------
    // States as plain ints: 0 idle, 1 settling, 2 armed, 3 halted.
    int         m_state [2];
    int         m_arm_at[2];   // cycle number at which settling ends
    logic [7:0] m_mask  [2];
    logic [7:0] m_seen  [2];   // synchronized flags as last observed while armed
    logic [7:0] m_stk   [2];
    bit         m_fv    [2];
    int         m_fch   [2];
    int         m_cnt   [2];
    bit         m_irq   [2];
    logic [7:0] hist[$];       // err_in samples, newest last
    int         cyc;
    logic [7:0] m_s, m_new, m_old;
    int         m_nxt;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int cnt_max(input int inst);
        return (inst == 0) ? 255 : 3;
    endfunction

    function automatic logic [7:0] exp_dis(input int inst);
        return (m_state[inst] == 2) ? ~m_mask[inst] : 8'hFF;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_state[i] = 0; m_arm_at[i] = 0; m_mask[i] = 0; m_seen[i] = 0;
                m_stk[i] = 0; m_fv[i] = 0; m_fch[i] = 0; m_cnt[i] = 0; m_irq[i] = 0;
            end
            hist = '{8'h00, 8'h00};
            cyc = 0;
        end else begin
            cyc++;
            m_s = hist[0];  // value sampled two edges ago
            for (int i = 0; i < 2; i++) begin
                m_new = (m_state[i] == 2) ? (m_s & ~m_seen[i] & m_mask[i]) : 8'h00;
                m_old = m_stk[i];
                if (clr) begin
                    m_stk[i] = 0; m_fv[i] = 0; m_fch[i] = 0; m_cnt[i] = 0; m_irq[i] = 0;
                end else begin
                    m_irq[i] = (m_old != 0);
                end
                if (m_new != 0) begin
                    m_stk[i] = m_stk[i] | m_new;
                    m_cnt[i] = m_cnt[i] + $countones(m_new);
                    if (m_cnt[i] > cnt_max(i)) m_cnt[i] = cnt_max(i);
                    if (!m_fv[i]) begin
                        m_fv[i] = 1; m_fch[i] = lowest(m_new);
                    end
                end
                m_nxt = m_state[i];
                if (m_state[i] == 0 && start) begin
                    m_mask[i] = mask; m_arm_at[i] = cyc + 16; m_nxt = 1;
                end else if (m_state[i] == 1 && cyc == m_arm_at[i]) begin
                    m_seen[i] = m_s; m_nxt = 2;
                end else if (m_state[i] == 2) begin
                    m_seen[i] = m_s;
                    if (m_new != 0 && i == 0) m_nxt = 3;
                end else if (m_state[i] == 3 && clr) begin
                    m_arm_at[i] = cyc + 16; m_nxt = 1;
                end
                if (stop) m_nxt = 0;
                m_state[i] = m_nxt;
            end
            void'(hist.pop_front());
            hist.push_back(err_in);
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            cmp("A.state", {30'd0, state_a}, m_state[0]);
            cmp("A.det_dis", {24'd0, dis_a}, {24'd0, exp_dis(0)});
            cmp("A.sticky", {24'd0, stk_a}, {24'd0, m_stk[0]});
            cmp("A.first_valid", {31'd0, fv_a}, {31'd0, m_fv[0]});
            cmp("A.first_ch", {29'd0, fch_a}, m_fch[0]);
            cmp("A.cnt", {24'd0, cnt_a}, m_cnt[0]);
            cmp("A.irq", {31'd0, irq_a}, {31'd0, m_irq[0]});
            cmp("B.state", {30'd0, state_b}, m_state[1]);
            cmp("B.det_dis", {24'd0, dis_b}, {24'd0, exp_dis(1)});
            cmp("B.sticky", {24'd0, stk_b}, {24'd0, m_stk[1]});
            cmp("B.first_valid", {31'd0, fv_b}, {31'd0, m_fv[1]});
            cmp("B.first_ch", {29'd0, fch_b}, m_fch[1]);
            cmp("B.cnt", {30'd0, cnt_b}, m_cnt[1]);
            cmp("B.irq", {31'd0, irq_b}, {31'd0, m_irq[1]});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic arm(input logic [7:0] m);
        mask = m; start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b0;
        chk_on = 1'b1;
        tick(3);
        cmp("lit reset det_dis", {24'd0, dis_a}, 32'hFF);
        cmp("lit reset state", {30'd0, state_a}, 32'd0);
        cmp("lit reset cnt", {24'd0, cnt_a}, 32'd0);
        rst = 1'b1;
        tick(2);

        // Reset/arm with mask 0F
        arm(8'h0F);
        cmp("lit arm settle state", {30'd0, state_a}, 32'd1);
        tick(15);
        cmp("lit settle last det_dis", {24'd0, dis_a}, 32'hFF);
        cmp("lit settle last state", {30'd0, state_b}, 32'd1);
        tick(1);
        cmp("lit armed state", {30'd0, state_a}, 32'd2);
        cmp("lit armed det_dis", {24'd0, dis_a}, 32'hF0);

        // Single error on channel 2
        err_in = 8'h04;
        tick(2);
        cmp("lit single pre sticky", {24'd0, stk_a}, 32'h00);
        tick(1);
        cmp("lit single sticky", {24'd0, stk_a}, 32'h04);
        cmp("lit single first_ch", {29'd0, fch_a}, 32'd2);
        cmp("lit single cnt", {24'd0, cnt_a}, 32'd1);
        cmp("lit single halt", {30'd0, state_a}, 32'd3);
        cmp("lit single halt dis", {24'd0, dis_a}, 32'hFF);
        cmp("lit single irq early", {31'd0, irq_a}, 32'd0);
        cmp("lit single B armed", {30'd0, state_b}, 32'd2);
        tick(1);
        cmp("lit single irq", {31'd0, irq_a}, 32'd1);

        // Masked and pre-existing errors
        stop = 1'b1; clr = 1'b1; err_in = 8'h20;
        tick(1);
        stop = 1'b0; clr = 1'b0;
        cmp("lit stop idle", {30'd0, state_a}, 32'd0);
        cmp("lit clr sticky", {24'd0, stk_b}, 32'h00);
        tick(3);
        arm(8'h3F);
        tick(16);
        cmp("lit masked armed dis", {24'd0, dis_a}, 32'hC0);
        err_in = 8'hA0;
        tick(5);
        cmp("lit masked sticky", {24'd0, stk_a}, 32'h00);
        cmp("lit masked cnt", {24'd0, cnt_a}, 32'd0);
        cmp("lit masked state", {30'd0, state_a}, 32'd2);

        // Simultaneous errors and saturation
        stop = 1'b1; clr = 1'b1; err_in = 8'h00;
        tick(1);
        stop = 1'b0; clr = 1'b0;
        tick(3);
        arm(8'hFF);
        tick(16);
        cmp("lit all armed dis", {24'd0, dis_b}, 32'h00);
        err_in = 8'h42;
        tick(3);
        cmp("lit simul first_ch", {29'd0, fch_b}, 32'd1);
        cmp("lit simul cnt", {30'd0, cnt_b}, 32'd2);
        cmp("lit simul sticky", {24'd0, stk_a}, 32'h42);
        err_in = 8'h43;
        tick(3);
        cmp("lit sat cnt 1", {30'd0, cnt_b}, 32'd3);
        err_in = 8'h42;
        tick(4);
        err_in = 8'h43;
        tick(3);
        cmp("lit sat cnt 2", {30'd0, cnt_b}, 32'd3);
        cmp("lit sat A held", {24'd0, cnt_a}, 32'd2);

        // clr colliding with new error on channel 4
        err_in = 8'h53;
        tick(2);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        cmp("lit coll sticky", {24'd0, stk_b}, 32'h10);
        cmp("lit coll cnt", {30'd0, cnt_b}, 32'd1);
        cmp("lit coll first_ch", {29'd0, fch_b}, 32'd4);
        cmp("lit halt clr settle", {30'd0, state_a}, 32'd1);
        tick(20);

        // start and stop together, then reset mid-settle
        stop = 1'b1;
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        cmp("lit start+stop", {30'd0, state_a}, 32'd0);
        arm(8'hFF);
        tick(4);
        cmp("lit pre-rst settle", {30'd0, state_b}, 32'd1);
        #2 rst = 1'b0;
        #1;
        cmp("lit rst state", {30'd0, state_b}, 32'd0);
        cmp("lit rst dis", {24'd0, dis_b}, 32'hFF);
        cmp("lit rst sticky", {24'd0, stk_b}, 32'h00);
        cmp("lit rst first_ch", {29'd0, fch_b}, 32'd0);
        tick(2);
        rst = 1'b1;
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/glitch_mon_ctrl.md
# glitch_mon_ctrl

Arming and collection controller for a bank of NCH glitch detectors in the checker layer. It gates each detector's disable input through an arm/settle/halt sequence. It synchronizes the detectors' sticky error flags and captures per-channel sticky status, the first-failing channel and a saturating event count. Bench code and tests configure, arm, poll and clear it through a small pulse interface.

## Interface
Parameters:
- NCH, 8, number of detector channels (1..32)
- SETTLE_CYC, 16, clk cycles detectors stay disabled after arming (>=1)
- CNT_W, 8, width of event counter
- HALT_ON_ERR, 1, 1: stop monitoring on first error; 0: keep monitoring

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse: arm using ch_en_mask
- stop  in  1  single-cycle pulse: return to IDLE
- clr  in  1  single-cycle pulse: clear captured status
- ch_en_mask  in  NCH  channel enables, latched on accepted start
- err_in  in  NCH  detector err outputs, asynchronous to clk, sticky-high
- det_dis  out  NCH  per-channel detector disable, 1 = disabled
- state  out  2  0 IDLE, 1 SETTLE, 2 ARMED, 3 HALT
- err_sticky  out  NCH  per-channel captured error
- first_valid  out  1  first_ch is valid
- first_ch  out  $clog2(NCH) (min 1)  lowest-index channel of first error cycle
- err_cnt  out  CNT_W  saturating count of captured channel errors
- irq  out  1  registered OR of err_sticky

## Operation
- Reset values: state=IDLE, det_dis=all 1, err_sticky=0, first_valid=0, first_ch=0, err_cnt=0, irq=0, latched mask=0, sync/edge registers=0.
- err_in passes through a 2-flop synchronizer per bit, giving s. An edge register e holds the previous s.
- new_err = s & ~e & mask_q. It is evaluated only in ARMED.
- States:
  - IDLE: det_dis all 1. On start, latch mask_q=ch_en_mask, load settle counter with SETTLE_CYC-1, go to SETTLE.
  - SETTLE: det_dis all 1. The counter decrements each cycle. At 0, load e=s (pre-existing high flags are ignored) and go to ARMED.
  - ARMED: det_dis = ~mask_q.
    - Each cycle, e<=s and err_sticky |= new_err.
    - err_cnt += popcount(new_err), saturating at 2^CNT_W-1.
    - If new_err!=0 and first_valid==0: first_valid<=1, first_ch<=lowest set index of new_err.
    - If new_err!=0 and HALT_ON_ERR: go to HALT.
  - HALT: det_dis all 1. Captured status is held. clr re-enters SETTLE, reloading the counter and keeping mask_q.
- stop in any state: go to IDLE, det_dis all 1. Captured status is kept.
- clr in any state zeroes err_sticky, first_valid, first_ch, err_cnt and irq. It does not change state, except HALT→SETTLE.
- start is ignored outside IDLE.
- Simultaneous events:
  - stop beats start and clr's state effect; clr's status clear still applies.
  - clr plus new_err in the same ARMED cycle: the new error wins. The result equals status cleared then this cycle's new_err applied (err_cnt=popcount, first_valid=1).
  - A channel masked off never sets status, even if its err_in is high.
- Detectors hold err permanently, so each channel contributes at most one edge per arm unless err_in is externally released and re-asserted. Re-assertion after release counts again.
- Asynchronous rst assertion mid-sequence immediately forces all reset values, including det_dis=all 1.

## Timing
- err_in rising before clk edge k: s high after edge k+1. err_sticky, err_cnt and first_* update at edge k+2. irq updates at edge k+3.
- start sampled at edge k: state=SETTLE after k. ARMED after edge k+SETTLE_CYC. det_dis releases at the same edge.
- stop at edge k: IDLE and det_dis all 1 after k.
- ARMED→HALT occurs at the same edge that sets status. det_dis is all 1 from then on.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Reset/arm: rst low→high, start with mask=8'h0F. Expect det_dis=8'hFF for 16 cycles after start, then 8'hF0, with state IDLE→SETTLE→ARMED.
- Single error: ARMED, HALT_ON_ERR=1, raise err_in[2]. Expect err_sticky=8'h04, first_ch=2, err_cnt=1 at edge k+2, state=HALT, det_dis=8'hFF, and irq one cycle later.
- Masked and pre-existing: err_in[5] high before start with mask=8'h3F, err_in[7] raised while ARMED. Expect no status change, err_cnt=0.
- Simultaneous and saturation: HALT_ON_ERR=0, CNT_W=2, raise err_in[1] and err_in[6] together. Expect first_ch=1, err_cnt=2. Then pulse err_in[0] low/high twice. Expect err_cnt saturates at 3.
- clr/new error collision: clr in the same cycle that new_err=8'h10. Expect err_sticky=8'h10, err_cnt=1, first_ch=4.
- Priority/reset: start and stop in the same cycle → IDLE. Assert rst mid-SETTLE → immediate reset values.
